// File: rtl/alu_unit.sv
// alu_unit: RISC-V integer ALU, XLEN 32 or 64; outputs registered, latency 1, one op per cycle, no backpressure.
// Zbb operators (codes 21-34) exist only when ALU_BITMANIP_EN is defined.
module alu_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [6:0]      operator_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic [XLEN-1:0] result_o,
  output logic            alu_branch_res_o
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [6:0] {
    OP_ADD  = 7'd0,  OP_SUB  = 7'd1,  OP_ADDW = 7'd2,  OP_SUBW = 7'd3,
    OP_XOR  = 7'd4,  OP_OR   = 7'd5,  OP_AND  = 7'd6,
    OP_SRA  = 7'd7,  OP_SRL  = 7'd8,  OP_SLL  = 7'd9,
    OP_SRLW = 7'd10, OP_SLLW = 7'd11, OP_SRAW = 7'd12,
    OP_LTS  = 7'd13, OP_LTU  = 7'd14, OP_GES  = 7'd15, OP_GEU  = 7'd16,
    OP_EQ   = 7'd17, OP_NE   = 7'd18, OP_SLTS = 7'd19, OP_SLTU = 7'd20,
    OP_ANDN = 7'd21, OP_ORN  = 7'd22, OP_XNOR = 7'd23,
    OP_CLZ  = 7'd24, OP_CTZ  = 7'd25, OP_CPOP = 7'd26,
    OP_MAX  = 7'd27, OP_MAXU = 7'd28, OP_MIN  = 7'd29, OP_MINU = 7'd30,
    OP_SEXTB = 7'd31, OP_SEXTH = 7'd32, OP_ROL = 7'd33, OP_ROR = 7'd34
  } alu_op_e;

  logic [SHW-1:0]    shamt;
  logic [4:0]        shamt_w;
  logic signed [31:0] addw, subw, srlw, sllw, sraw;
  logic              lts, ltu, eq;
  logic [XLEN-1:0]   res;
  logic              br;

  assign shamt   = operand_b_i[SHW-1:0];
  assign shamt_w = operand_b_i[4:0];
  // 32-bit results are declared signed so the XLEN cast below sign-extends from bit 31
  assign addw = operand_a_i[31:0] + operand_b_i[31:0];
  assign subw = operand_a_i[31:0] - operand_b_i[31:0];
  assign srlw = operand_a_i[31:0] >> shamt_w;
  assign sllw = operand_a_i[31:0] << shamt_w;
  assign sraw = $signed(operand_a_i[31:0]) >>> shamt_w;
  assign lts  = $signed(operand_a_i) < $signed(operand_b_i);
  assign ltu  = operand_a_i < operand_b_i;
  assign eq   = operand_a_i == operand_b_i;

`ifdef ALU_BITMANIP_EN
  localparam int CW = SHW + 1;
  logic [CW-1:0]     clz, ctz, cpop;
  logic [SHW:0]      rot_inv;
  logic [XLEN-1:0]   rol, ror;
  logic signed [7:0]  a_byte;
  logic signed [15:0] a_half;

  always_comb begin
    clz  = CW'(XLEN);
    ctz  = CW'(XLEN);
    cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (operand_a_i[i]) clz = CW'(XLEN - 1 - i);
      cpop = cpop + CW'(operand_a_i[i]);
    end
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (operand_a_i[i]) ctz = CW'(i);
    end
  end

  // a shift by XLEN (rot_inv when shamt==0) yields zero, so rotate-by-0 returns a
  assign rot_inv = (SHW+1)'(XLEN) - {1'b0, shamt};
  assign rol     = (operand_a_i << shamt) | (operand_a_i >> rot_inv);
  assign ror     = (operand_a_i >> shamt) | (operand_a_i << rot_inv);
  assign a_byte  = operand_a_i[7:0];
  assign a_half  = operand_a_i[15:0];
`endif

  always_comb begin
    res = '0;
    br  = 1'b0;
    case (operator_i)
      OP_ADD:  res = operand_a_i + operand_b_i;
      OP_SUB:  res = operand_a_i - operand_b_i;
      OP_ADDW: res = XLEN'(addw);
      OP_SUBW: res = XLEN'(subw);
      OP_XOR:  res = operand_a_i ^ operand_b_i;
      OP_OR:   res = operand_a_i | operand_b_i;
      OP_AND:  res = operand_a_i & operand_b_i;
      OP_SRA:  res = $signed(operand_a_i) >>> shamt;
      OP_SRL:  res = operand_a_i >> shamt;
      OP_SLL:  res = operand_a_i << shamt;
      OP_SRLW: res = XLEN'(srlw);
      OP_SLLW: res = XLEN'(sllw);
      OP_SRAW: res = XLEN'(sraw);
      OP_LTS:  br  = lts;
      OP_LTU:  br  = ltu;
      OP_GES:  br  = !lts;
      OP_GEU:  br  = !ltu;
      OP_EQ:   br  = eq;
      OP_NE:   br  = !eq;
      OP_SLTS: res = {{(XLEN-1){1'b0}}, lts};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, ltu};
`ifdef ALU_BITMANIP_EN
      OP_ANDN:  res = operand_a_i & ~operand_b_i;
      OP_ORN:   res = operand_a_i | ~operand_b_i;
      OP_XNOR:  res = ~(operand_a_i ^ operand_b_i);
      OP_CLZ:   res = XLEN'(clz);
      OP_CTZ:   res = XLEN'(ctz);
      OP_CPOP:  res = XLEN'(cpop);
      OP_MAX:   res = lts ? operand_b_i : operand_a_i;
      OP_MAXU:  res = ltu ? operand_b_i : operand_a_i;
      OP_MIN:   res = lts ? operand_a_i : operand_b_i;
      OP_MINU:  res = ltu ? operand_a_i : operand_b_i;
      OP_SEXTB: res = XLEN'(a_byte);
      OP_SEXTH: res = XLEN'(a_half);
      OP_ROL:   res = rol;
      OP_ROR:   res = ror;
`endif
      default: begin
        res = '0;
        br  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o         <= '0;
      alu_branch_res_o <= 1'b0;
    end else begin
      result_o         <= res;
      alu_branch_res_o <= br;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit (XLEN=64): directed corner cases plus random ops against an arithmetic reference model.
// Honours ALU_BITMANIP_EN the same way the design does.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [63:0] a, b;
  logic [63:0] res;
  logic        br;

  int total = 0;
  int bad   = 0;
  logic [63:0] prev_r;
  logic        prev_b;

  alu_unit #(.XLEN(64)) dut (
    .clk_i(clk), .rst_i(rst), .operator_i(op),
    .operand_a_i(a), .operand_b_i(b),
    .result_o(res), .alu_branch_res_o(br)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [6:0] o, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic bb);
    longint sx = x;
    longint sy = y;
    int w;
    int n;
    r  = 64'd0;
    bb = 1'b0;
    case (o)
      0:  r = x + y;
      1:  r = x - y;
      2:  begin w = int'(x[31:0]) + int'(y[31:0]); r = longint'(w); end
      3:  begin w = int'(x[31:0]) - int'(y[31:0]); r = longint'(w); end
      4:  r = x ^ y;
      5:  r = x | y;
      6:  r = x & y;
      7:  r = sx >>> y[5:0];
      8:  r = x >> y[5:0];
      9:  r = x << y[5:0];
      10: begin w = int'(x[31:0] >> y[4:0]); r = longint'(w); end
      11: begin w = int'(x[31:0] << y[4:0]); r = longint'(w); end
      12: begin w = int'(x[31:0]); w = w >>> y[4:0]; r = longint'(w); end
      13: bb = sx < sy;
      14: bb = x < y;
      15: bb = sx >= sy;
      16: bb = x >= y;
      17: bb = x == y;
      18: bb = x != y;
      19: r = (sx < sy) ? 64'd1 : 64'd0;
      20: r = (x < y) ? 64'd1 : 64'd0;
`ifdef ALU_BITMANIP_EN
      21: r = x & ~y;
      22: r = x | ~y;
      23: r = ~(x ^ y);
      24: begin n = 0; while (n < 64 && !x[63-n]) n++; r = 64'(n); end
      25: begin n = 0; while (n < 64 && !x[n]) n++; r = 64'(n); end
      26: begin n = 0; for (int i = 0; i < 64; i++) if (x[i]) n++; r = 64'(n); end
      27: r = (sx > sy) ? x : y;
      28: r = (x > y) ? x : y;
      29: r = (sx < sy) ? x : y;
      30: r = (x < y) ? x : y;
      31: r = longint'(byte'(x[7:0]));
      32: r = longint'(shortint'(x[15:0]));
      33: begin n = int'(y[5:0]); r = (x << n) | (x >> ((64 - n) % 64)); end
      34: begin n = int'(y[5:0]); r = (x >> n) | (x << ((64 - n) % 64)); end
`endif
      default: r = 64'd0;
    endcase
  endfunction

  // Called at a negedge: drives the op, confirms outputs hold until the edge, then checks the captured result.
  task automatic do_op(input string tag, input logic [6:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] er;
    logic        eb;
    model(o, x, y, er, eb);
    op = o; a = x; b = y;
    #1;
    chk({tag, "_hold_r"}, res, prev_r);
    chk({tag, "_hold_br"}, 64'(br), 64'(prev_b));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_r"}, res, er);
    chk({tag, "_br"}, 64'(br), 64'(eb));
    prev_r = er;
    prev_b = eb;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [6:0]  o;
    logic [63:0] x;
    rst = 1'b1; op = 7'd0; a = 64'd5; b = 64'd7;
    #2;
    chk("reset_r", res, 64'd0);
    chk("reset_br", 64'(br), 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_held_r", res, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_add", res, 64'd12);

    // reset between edges must clear the outputs without a clock edge
    a = 64'd9; b = 64'd9;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_r", res, 64'd0);
    chk("async_reset_br", 64'(br), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_edge_after_reset", res, 64'd18);
    prev_r = 64'd18;
    prev_b = 1'b0;

    do_op("add_wrap", 7'd0, '1, 64'd1);
    do_op("subw_neg", 7'd3, 64'd0, 64'd1);
    do_op("addw_ovf", 7'd2, 64'h7FFF_FFFF, 64'd1);
    do_op("sra_min", 7'd7, 64'h8000_0000_0000_0000, 64'd63);
    do_op("sll_mask", 7'd9, 64'd1, 64'h41);
    do_op("srl_zero", 7'd8, 64'hDEAD_BEEF_0123_4567, 64'd0);
    do_op("srlw", 7'd10, 64'hFFFF_FFFF_8000_0000, 64'd31);
    do_op("sraw", 7'd12, 64'h0000_0000_8000_0000, 64'd4);
    do_op("lts", 7'd13, '1, 64'd1);
    do_op("ltu", 7'd14, '1, 64'd1);
    do_op("slts", 7'd19, '1, 64'd1);
    do_op("sltu", 7'd20, '1, 64'd1);
    do_op("eq_same", 7'd17, 64'h1234, 64'h1234);
    do_op("ne_same", 7'd18, 64'h1234, 64'h1234);
    do_op("lts_min0", 7'd13, 64'h8000_0000_0000_0000, 64'd0);
    do_op("ltu_min0", 7'd14, 64'h8000_0000_0000_0000, 64'd0);
    do_op("undef100", 7'd100, {$urandom, $urandom}, {$urandom, $urandom});
`ifdef ALU_BITMANIP_EN
    do_op("clz_1", 7'd24, 64'd1, 64'd0);
    do_op("clz_0", 7'd24, 64'd0, 64'd0);
    do_op("ctz_0", 7'd25, 64'd0, 64'd0);
    do_op("cpop", 7'd26, 64'hF0F0, 64'd0);
    do_op("ror_1", 7'd34, 64'd1, 64'd1);
    do_op("rol_0", 7'd33, 64'h1234_5678_9ABC_DEF0, 64'd0);
    do_op("min", 7'd29, '1, 64'd1);
    do_op("minu", 7'd30, '1, 64'd1);
    do_op("sextb", 7'd31, 64'h80, 64'd0);
`else
    do_op("clz_absent", 7'd24, 64'd1, 64'd0);
    do_op("rol_absent", 7'd33, 64'd3, 64'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) o = 7'($urandom_range(35, 127));
      else o = 7'($urandom_range(0, 34));
      x = rnd64();
      do_op($sformatf("rand%0d_op%0d", i, o), o, x, ($urandom_range(0, 7) == 0) ? x : rnd64());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
